// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and
// data-memory freeze for a classic five-stage pipeline. It also carries the
// QED valid bit alongside IF/ID and keeps stall and timeout bookkeeping.
//
// Handshake note: this block has no valid/ready channels. dmem_req/dmem_ack
// work as a level-sensitive wait: the pipeline freezes in every cycle where a
// request is pending without its acknowledge, and resumes in the ack cycle.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        qed_vld_in,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        qed_vld_out,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_e;

    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        qed_q, qed_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mto_q, mto_d;

    logic mem_stall;
    logic load_use;
    logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c;

    assign mem_stall = dmem_req & ~dmem_ack;
    assign load_use  = ex_memread && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    // Next-state and control outputs; priority: freeze > flush > branch > load-use.
    always_comb begin
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        wait_cnt_d     = wait_cnt_q;

        if (mem_stall) begin
            // Freeze the whole front end; a pending flush stays asserted.
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            if_id_flush_c = (state_q == ST_FLUSH);
            case (state_q)
                ST_FLUSH: ;
                ST_MEMWAIT: begin
                    if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
                end
                default: begin
                    state_d    = ST_MEMWAIT;
                    wait_cnt_d = 8'd1;
                end
            endcase
        end else if (state_q == ST_FLUSH) begin
            // Wrong-path instructions: branches and hazards here are ignored.
            if_id_write_c  = 1'b0;
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            flush_cnt_d    = flush_cnt_q - 3'd1;
            if (flush_cnt_q <= 3'd1) begin
                state_d     = ST_RUN;
                flush_cnt_d = 3'd0;
            end
        end else begin
            // RUN, or MEMWAIT in its ack cycle, behaves as normal RUN.
            state_d    = ST_RUN;
            wait_cnt_d = 8'd0;
            if (ex_branch_taken) begin
                if_id_write_c  = 1'b0;
                if_id_flush_c  = 1'b1;
                id_ex_bubble_c = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end else if (load_use) begin
                pc_write_c     = 1'b0;
                if_id_write_c  = 1'b0;
                id_ex_bubble_c = 1'b1;
            end
        end
    end

    // Bookkeeping: QED valid alignment, saturating stall count, sticky timeout.
    always_comb begin
        qed_d       = qed_q;
        stall_cnt_d = stall_cnt_q;
        mto_d       = mto_q;
        if (if_id_flush_c)      qed_d = 1'b0;
        else if (if_id_write_c) qed_d = qed_vld_in;
        if (!pc_write_c && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
        if ((state_q == ST_MEMWAIT) && (wait_cnt_q == TIMEOUT_VAL)) mto_d = 1'b1;
    end

    // State and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= 8'd0;
            qed_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
            mto_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            qed_q       <= qed_d;
            stall_cnt_q <= stall_cnt_d;
            mto_q       <= mto_d;
        end
    end

    // While reset is held the pipeline is held and IF/ID kept clear.
    assign pc_write     = reset_n ? pc_write_c     : 1'b0;
    assign if_id_write  = reset_n ? if_id_write_c  : 1'b0;
    assign if_id_flush  = reset_n ? if_id_flush_c  : 1'b1;
    assign id_ex_bubble = reset_n ? id_ex_bubble_c : 1'b1;

    assign qed_vld_out  = qed_q;
    assign state        = state_q;
    assign stall_cnt    = stall_cnt_q;
    assign mem_timeout  = mto_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=3).
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs2, ex_memread, ex_branch_taken;
    logic        dmem_req, dmem_ack, qed_vld_in;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic        qed_vld_out, mem_timeout;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Clock
    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .qed_vld_in(qed_vld_in),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .qed_vld_out(qed_vld_out), .state(state),
        .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
    );

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        uses;
        logic [4:0]  rd;
        logic        mr, br, req, ack, qin;
        logic [3:0]  ctl;   // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
        logic [1:0]  st;
        logic [15:0] sc;
        logic        qo, to;
    } vec_t;

    vec_t vecs[32];
    int   nvec = 0;

    task automatic add_vec(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                           input logic [4:0] rd, input logic mr, input logic br,
                           input logic req, input logic ack, input logic qin,
                           input logic [3:0] ctl, input logic [1:0] st,
                           input logic [15:0] sc, input logic qo, input logic to);
        vecs[nvec] = '{rs1, rs2, uses, rd, mr, br, req, ack, qin, ctl, st, sc, qo, to};
        nvec++;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.uses;
        ex_rd = v.rd; ex_memread = v.mr; ex_branch_taken = v.br;
        dmem_req = v.req; dmem_ack = v.ack; qed_vld_in = v.qin;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; ex_rd = 0; ex_memread = 0;
        ex_branch_taken = 0; dmem_req = 0; dmem_ack = 0; qed_vld_in = 0;
    endtask

    function automatic logic [3:0] ctl_now();
        return {pc_write, if_id_write, if_id_flush, id_ex_bubble};
    endfunction

    initial begin
        idle_inputs();
        // Reset state, checked before any clock edge.
        #2 reset_n = 1'b0;
        #2;
        check("rst_ctl", 16'(ctl_now()), 16'h3);
        check("rst_state", 16'(state), 16'h0);
        check("rst_stall_cnt", stall_cnt, 16'h0);
        check("rst_qed", 16'(qed_vld_out), 16'h0);
        check("rst_timeout", 16'(mem_timeout), 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);

        //       rs1 rs2 use rd mr br rq ak qi   ctl    st  sc  qo to
        add_vec(0,  0,  0,  0, 0, 0, 0, 0, 1, 4'b1100, 0, 0,  0, 0); // v0 normal
        add_vec(5,  0,  0,  5, 1, 0, 0, 0, 0, 4'b0001, 0, 0,  1, 0); // v1 load-use rs1
        add_vec(0,  0,  0,  0, 1, 0, 0, 0, 0, 4'b1100, 0, 1,  1, 0); // v2 rd=0 no stall
        add_vec(3,  7,  1,  7, 1, 0, 0, 0, 1, 4'b0001, 0, 1,  0, 0); // v3 load-use rs2
        add_vec(3,  7,  0,  7, 1, 0, 0, 0, 1, 4'b1100, 0, 2,  0, 0); // v4 rs2 unused
        add_vec(0,  0,  0,  0, 0, 1, 0, 0, 1, 4'b1011, 0, 2,  1, 0); // v5 branch
        add_vec(5,  0,  0,  5, 1, 1, 0, 0, 1, 4'b1011, 1, 2,  0, 0); // v6 flush, ignored evts
        add_vec(0,  0,  0,  0, 0, 0, 0, 0, 1, 4'b1100, 0, 2,  0, 0); // v7 back in run
        add_vec(0,  0,  0,  0, 0, 0, 1, 0, 0, 4'b0000, 0, 2,  1, 0); // v8 mem stall 1
        add_vec(0,  0,  0,  0, 0, 0, 1, 0, 0, 4'b0000, 2, 3,  1, 0); // v9 mem stall 2
        add_vec(0,  0,  0,  0, 0, 0, 1, 0, 0, 4'b0000, 2, 4,  1, 0); // v10 mem stall 3
        add_vec(0,  0,  0,  0, 0, 0, 1, 0, 0, 4'b0000, 2, 5,  1, 0); // v11 mem stall 4
        add_vec(0,  0,  0,  0, 0, 0, 1, 1, 0, 4'b1100, 2, 6,  1, 1); // v12 ack cycle
        add_vec(0,  0,  0,  0, 0, 0, 0, 0, 1, 4'b1100, 0, 6,  0, 1); // v13 timeout sticky
        add_vec(5,  0,  0,  5, 1, 1, 1, 0, 0, 4'b0000, 0, 6,  1, 1); // v14 all events
        add_vec(0,  0,  0,  0, 0, 1, 1, 1, 1, 4'b1011, 2, 7,  1, 1); // v15 ack + branch
        add_vec(0,  0,  0,  0, 0, 0, 1, 0, 1, 4'b0010, 1, 7,  0, 1); // v16 freeze in flush
        add_vec(0,  0,  0,  0, 0, 0, 0, 0, 1, 4'b1011, 1, 8,  0, 1); // v17 flush resumes
        add_vec(0,  0,  0,  0, 0, 0, 0, 0, 0, 4'b1100, 0, 8,  0, 1); // v18 run

        for (int i = 0; i < nvec; i++) begin
            #1 drive(vecs[i]);
            #3;
            check($sformatf("v%0d_ctl", i), 16'(ctl_now()), 16'(vecs[i].ctl));
            check($sformatf("v%0d_state", i), 16'(state), 16'(vecs[i].st));
            check($sformatf("v%0d_stall_cnt", i), stall_cnt, vecs[i].sc);
            check($sformatf("v%0d_qed", i), 16'(qed_vld_out), 16'(vecs[i].qo));
            check($sformatf("v%0d_timeout", i), 16'(mem_timeout), 16'(vecs[i].to));
            @(posedge clk);
        end

        // Asynchronous reset in the middle of a flush.
        #1 idle_inputs(); ex_branch_taken = 1'b1;
        @(posedge clk);
        #1 idle_inputs();
        check("flush_entered", 16'(state), 16'h1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_flush_ctl", 16'(ctl_now()), 16'h3);
        check("rst_flush_state", 16'(state), 16'h0);
        check("rst_flush_stall_cnt", stall_cnt, 16'h0);
        check("rst_flush_timeout", 16'(mem_timeout), 16'h0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #3;
        check("post_flush_rst_ctl", 16'(ctl_now()), 16'hC);
        check("post_flush_rst_state", 16'(state), 16'h0);

        // Timeout build-up in MEMWAIT, then reset abandons the wait.
        @(posedge clk);
        #1 dmem_req = 1'b1; dmem_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("wait_state", 16'(state), 16'h2);
        check("wait_timeout", 16'(mem_timeout), 16'h1);
        check("wait_stall_cnt", stall_cnt, 16'h4);
        reset_n = 1'b0;
        #1;
        check("rst_wait_ctl", 16'(ctl_now()), 16'h3);
        check("rst_wait_state", 16'(state), 16'h0);
        check("rst_wait_timeout", 16'(mem_timeout), 16'h0);
        @(negedge clk) begin
            reset_n = 1'b1;
            idle_inputs();
        end
        @(posedge clk);
        #3;
        check("post_wait_rst_ctl", 16'(ctl_now()), 16'hC);
        check("post_wait_rst_state", 16'(state), 16'h0);
        check("post_wait_rst_stall_cnt", stall_cnt, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2: number of cycles the IF/ID register is flushed after a taken branch (legal range 1..7).
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 255: MEMWAIT cycle count at which mem_timeout is raised (legal range 1..255).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs2  in  1  ID instruction reads rs2.
REQ-007 ex_rd  in  5; ex_memread  in  1  destination register and load flag of the instruction in EX.
REQ-008 ex_branch_taken  in  1  taken branch or jump resolved in EX.
REQ-009 dmem_req, dmem_ack  in  1 each  data-memory request and completion.
REQ-010 qed_vld_in  in  1  QED valid bit arriving with the fetched instruction.
REQ-011 pc_write, if_id_write  out  1 each  PC and IF/ID write enables.
REQ-012 if_id_flush  out  1  synchronous clear of the IF/ID register.
REQ-013 id_ex_bubble  out  1  insert a NOP into ID/EX.
REQ-014 qed_vld_out  out  1  registered QED valid aligned with IF/ID contents.
REQ-015 state  out  2  FSM state: RUN=0, FLUSH=1, MEMWAIT=2 (3 unused).
REQ-016 stall_cnt  out  16  saturating count of cycles with pc_write=0.
REQ-017 mem_timeout  out  1  sticky memory-timeout error flag.

Function
REQ-018 mem_stall SHALL equal dmem_req AND NOT dmem_ack.
REQ-019 load_use SHALL equal ex_memread AND ex_rd!=0 AND (ex_rd==id_rs1 OR (id_uses_rs2 AND ex_rd==id_rs2)).
REQ-020 Outputs pc_write, if_id_write, if_id_flush and id_ex_bubble SHALL be combinational from state, the counters and the inputs; priority is mem_stall > FLUSH state > ex_branch_taken > load_use > normal.
REQ-021 Freeze (mem_stall=1, any state): pc_write=0, if_id_write=0, id_ex_bubble=0; if_id_flush=1 only in FLUSH, else 0; flush counter holds.
REQ-022 RUN, mem_stall=1: next state MEMWAIT, wait counter loads 1.
REQ-023 RUN, ex_branch_taken=1: pc_write=1, if_id_write=0, if_id_flush=1, id_ex_bubble=1; next state FLUSH with flush counter loaded to FLUSH_CYCLES-1, or stay RUN when FLUSH_CYCLES=1.
REQ-024 RUN, load_use=1: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1; state stays RUN (one bubble per hazard cycle).
REQ-025 RUN, no event: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
REQ-026 FLUSH, mem_stall=0: same outputs as REQ-023; flush counter decrements; counter==1 -> next state RUN; ex_branch_taken and load_use are ignored (wrong-path).
REQ-027 MEMWAIT: mem_stall=1 holds state and increments the wait counter (8-bit, saturating); mem_stall=0 applies the RUN rules REQ-023..025 combinationally in that same cycle and moves to the RUN next state (or to FLUSH per REQ-023).
REQ-028 mem_timeout SHALL set on the edge where the wait counter equals MEM_TIMEOUT in MEMWAIT, and SHALL remain 1 until reset.
REQ-029 qed_vld_out on each edge: 0 if if_id_flush; else qed_vld_in if if_id_write; else hold.
REQ-030 stall_cnt SHALL increment on each edge with pc_write=0 and SHALL saturate at 16'hFFFF.

Reset
REQ-031 reset_n=0 SHALL immediately force state=RUN, flush and wait counters=0, qed_vld_out=0, stall_cnt=0 and mem_timeout=0, regardless of clk.
REQ-032 While reset_n=0: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1.
REQ-033 Reset asserted mid-FLUSH or mid-MEMWAIT SHALL abandon the operation; the first cycle after release is normal RUN.

Verification
REQ-034 Load-use: ex_memread=1, ex_rd=5, id_rs1=5 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1, stall_cnt 0->1, state stays RUN; ex_rd=0 with id_rs1=0 -> no stall.
REQ-035 Branch with FLUSH_CYCLES=2: ex_branch_taken pulse -> if_id_flush=1 for exactly 2 cycles, state RUN->FLUSH->RUN, qed_vld_out=0 after each flushed edge; a second branch during FLUSH is ignored.
REQ-036 Memory wait: dmem_req=1, dmem_ack=0 for 4 cycles, then ack -> pc_write=0 for 4 cycles, state=MEMWAIT, stall_cnt=4, qed_vld_out held; normal writes in the ack cycle.
REQ-037 Timeout with MEM_TIMEOUT=3: dmem_ack held 0 -> mem_timeout=1 after the 3rd MEMWAIT edge, still 1 after ack.
REQ-038 Simultaneous events: mem_stall, ex_branch_taken and load_use together in RUN -> freeze outputs, next state MEMWAIT; async reset_n pulse mid-FLUSH -> outputs per REQ-032 at once, state=0.
